vpu_op_responder: RTL and testbench
===================================

Name: vpu_op_responder

Overview:
- VPU-side end of the CPU/VPU handshake driven by the decode/execute stage.
- When the CPU asserts VPU_start with an op code, eight 16-bit lane operands (V0_in..V7_in) and a scalar (RO_in), the block executes the op one lane per cycle.
- On completion it returns V0_out..V7_out and RO_out with a one-cycle VPU_data_we pulse, then reasserts VPU_rdy.
- It feeds the CPU's we_VPU, VPU_rdy and V*/RO write-back inputs.

Parameters:
DW, 16, lane/scalar data width (signed two's complement); all V*/RO ports are DW wide.

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
VPU_start  in  1  request from CPU; sampled only when VPU_rdy=1
VPU_op  in  3  operation code, latched with VPU_start
V0_in..V7_in  in  DW each  lane operands, latched with VPU_start
RO_in  in  DW  scalar operand, latched with VPU_start
VPU_rdy  out  1  1 = idle, will accept VPU_start
VPU_data_we  out  1  one-cycle pulse, V*_out/RO_out valid for write-back
V0_out..V7_out  out  DW each  lane results
RO_out  out  DW  scalar result / overflow count

Behaviour:
- One clock (clk); reset synchronous, active-low (rst_n sampled at posedge).
- Reset values: VPU_rdy=1, VPU_data_we=0, all V*_out=0, RO_out=0, state IDLE, lane counter 0.
- States: IDLE -> EXEC -> WB -> IDLE.
- IDLE, VPU_rdy=1:
  - VPU_start=1 at edge E0: latch op, lanes and scalar; go to EXEC, lane=0; VPU_rdy=0 after E0.
  - VPU_start=0: stay in IDLE.
- EXEC: one lane per edge (E1..E8 process lanes 0..7) into internal result registers. After lane 7, go to WB.
- WB, registered after E8:
  - VPU_data_we=1 for exactly one cycle.
  - V*_out/RO_out update at the same edge and stay valid while VPU_data_we=1.
  - E9 returns to IDLE: VPU_rdy=1, VPU_data_we=0.
- Latency: VPU_data_we high during the cycle following E8. Busy window is 9 cycles; next start can be accepted at E10.
- Outputs hold their last results until the next WB or reset.
- VPU_start while busy is ignored. No queuing, no error.
- Op codes (signed, per lane i, S = latched RO_in):
  - 000 ADD: V_i + S.
  - 001 SUB: V_i - S.
  - 010 MUL: low DW bits of V_i*S (one combinational multiplier, shared across lanes).
  - 011 SHL: V_i << S[3:0].
  - 100 SRA: V_i >>> S[3:0].
  - 101 MIN: min(V_i, S).
  - 110 MAX: max(V_i, S).
  - 111 SUM: V_out = V_in unchanged; RO_out = sum of the 8 lanes, wrapped to DW.
- RO_out by op:
  - ADD/SUB/MUL: count (0..8) of lanes whose true signed result does not fit in DW.
  - SHL/SRA/MIN/MAX: 0.
- rst_n=0 mid-EXEC or mid-WB: next edge goes to IDLE with reset values. No VPU_data_we pulse; partial results discarded.
- rst_n=0 coincident with VPU_start: reset wins.

Optional Feature:
- Macro: VPU_SAT_EN.
- Defined: ADD/SUB/MUL lane results that overflow saturate to 0x7FFF (positive) or 0x8000 (negative). RO_out still counts the overflowed lanes.
- Undefined: overflowed lanes wrap modulo 2^DW. RO_out counts the same way.
- All other ops are identical in both builds.

Test Plan:
- Reset, then ADD: V0..V7=1..8, RO_in=10, start at E0 -> VPU_rdy=0 from E0; VPU_data_we=1 only after E8; V_out=11..18; RO_out=0; VPU_rdy=1 after E9.
- SUB overflow: V0=0x8000, others 0, RO_in=1 -> RO_out=1.
  - Without VPU_SAT_EN: V0_out=0x7FFF.
  - With VPU_SAT_EN: V0_out=0x8000.
  - V1..V7_out=0xFFFF in both builds.
- MUL/SRA:
  - V0..V7=0x0100, RO_in=0x0100, MUL -> RO_out=8; V_out=0x0000 (wrap) or 0x7FFF (sat).
  - Then SRA with V0=0xFF00, RO_in=4 -> V0_out=0xFFF0.
- SUM: V0..V7=1..8 -> RO_out=0x0024; V_out=1..8; single VPU_data_we pulse.
- Busy/ignore: start ADD, then hold VPU_start=1 with different operands through E1..E9 -> exactly one VPU_data_we pulse with the first op's results. Second op is accepted at E10 only if VPU_start is still high; it completes with a pulse after E18.
- Reset mid-op: rst_n=0 for one cycle at E5 -> after E5 VPU_rdy=1, all outputs 0, no VPU_data_we pulse in the following 10 cycles without a new start.

Source files
------------

// File: rtl/vpu_op_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vpu_op_responder: VPU end of the CPU/VPU handshake. It runs one op       |
// | across eight lanes, one lane per cycle, then pulses write-back.          |
// | Optional: define VPU_SAT_EN to saturate ADD/SUB/MUL lane overflows.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vpu_op_responder #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          VPU_start,
  input  logic [2:0]    VPU_op,
  input  logic [DW-1:0] V0_in,
  input  logic [DW-1:0] V1_in,
  input  logic [DW-1:0] V2_in,
  input  logic [DW-1:0] V3_in,
  input  logic [DW-1:0] V4_in,
  input  logic [DW-1:0] V5_in,
  input  logic [DW-1:0] V6_in,
  input  logic [DW-1:0] V7_in,
  input  logic [DW-1:0] RO_in,
  output logic          VPU_rdy,
  output logic          VPU_data_we,
  output logic [DW-1:0] V0_out,
  output logic [DW-1:0] V1_out,
  output logic [DW-1:0] V2_out,
  output logic [DW-1:0] V3_out,
  output logic [DW-1:0] V4_out,
  output logic [DW-1:0] V5_out,
  output logic [DW-1:0] V6_out,
  output logic [DW-1:0] V7_out,
  output logic [DW-1:0] RO_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_SHL = 3'd3;
  localparam logic [2:0] OP_SRA = 3'd4;
  localparam logic [2:0] OP_MIN = 3'd5;
  localparam logic [2:0] OP_MAX = 3'd6;
  localparam logic [2:0] OP_SUM = 3'd7;

  state_t        state_q, state_d;
  logic [2:0]    lane_q, lane_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] v_q [8];
  logic [DW-1:0] v_d [8];
  logic [DW-1:0] s_q, s_d;
  logic [DW-1:0] res_q [8];
  logic [DW-1:0] res_d [8];
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] sum_q, sum_d;
  logic          rdy_q, rdy_d;
  logic          we_q, we_d;
  logic [DW-1:0] vout_q [8];
  logic [DW-1:0] vout_d [8];
  logic [DW-1:0] ro_q, ro_d;

  logic [DW-1:0] v_in [8];
  logic signed [DW-1:0] a, s;
  logic [DW:0]     add_x, sub_x;
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   lane_res;
  logic            lane_ovf, lane_neg;

  always_comb begin
    v_in[0] = V0_in; v_in[1] = V1_in; v_in[2] = V2_in; v_in[3] = V3_in;
    v_in[4] = V4_in; v_in[5] = V5_in; v_in[6] = V6_in; v_in[7] = V7_in;

    a     = v_q[lane_q];
    s     = s_q;
    add_x = {a[DW-1], a} + {s[DW-1], s};
    sub_x = {a[DW-1], a} - {s[DW-1], s};
    prod  = {{DW{a[DW-1]}}, a} * {{DW{s[DW-1]}}, s};

    lane_ovf = 1'b0;
    lane_neg = 1'b0;
    case (op_q)
      OP_ADD: begin
        lane_res = add_x[DW-1:0];
        lane_ovf = add_x[DW] ^ add_x[DW-1];
        lane_neg = add_x[DW];
      end
      OP_SUB: begin
        lane_res = sub_x[DW-1:0];
        lane_ovf = sub_x[DW] ^ sub_x[DW-1];
        lane_neg = sub_x[DW];
      end
      OP_MUL: begin
        // True product fits in DW only if its upper half is the sign extension of bit DW-1.
        lane_res = prod[DW-1:0];
        lane_ovf = prod[2*DW-1:DW-1] != {(DW+1){prod[DW-1]}};
        lane_neg = prod[2*DW-1];
      end
      OP_SHL:  lane_res = a << s[3:0];
      OP_SRA:  lane_res = a >>> s[3:0];
      OP_MIN:  lane_res = (a < s) ? a : s;
      OP_MAX:  lane_res = (a > s) ? a : s;
      default: lane_res = a;
    endcase
`ifdef VPU_SAT_EN
    if (lane_ovf)
      lane_res = lane_neg ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif

    state_d = state_q;
    lane_d  = lane_q;
    op_d    = op_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    rdy_d   = rdy_q;
    we_d    = we_q;
    ro_d    = ro_q;
    for (int i = 0; i < 8; i++) begin
      v_d[i]    = v_q[i];
      res_d[i]  = res_q[i];
      vout_d[i] = vout_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (VPU_start) begin
          for (int i = 0; i < 8; i++) v_d[i] = v_in[i];
          op_d    = VPU_op;
          s_d     = RO_in;
          lane_d  = 3'd0;
          cnt_d   = 4'd0;
          sum_d   = '0;
          rdy_d   = 1'b0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d[lane_q] = lane_res;
        cnt_d  = cnt_q + {3'b000, lane_ovf};
        sum_d  = sum_q + a;
        lane_d = lane_q + 3'd1;
        if (lane_q == 3'd7) begin
          for (int i = 0; i < 8; i++) vout_d[i] = res_d[i];
          case (op_q)
            OP_SUM:                 ro_d = sum_d;
            OP_ADD, OP_SUB, OP_MUL: ro_d = {{(DW-4){1'b0}}, cnt_d};
            default:                ro_d = '0;
          endcase
          we_d    = 1'b1;
          state_d = ST_WB;
        end
      end
      default: begin
        we_d    = 1'b0;
        rdy_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lane_q  <= 3'd0;
      op_q    <= 3'd0;
      s_q     <= '0;
      cnt_q   <= 4'd0;
      sum_q   <= '0;
      rdy_q   <= 1'b1;
      we_q    <= 1'b0;
      ro_q    <= '0;
      for (int i = 0; i < 8; i++) begin
        v_q[i]    <= '0;
        res_q[i]  <= '0;
        vout_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      op_q    <= op_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      ro_q    <= ro_d;
      for (int i = 0; i < 8; i++) begin
        v_q[i]    <= v_d[i];
        res_q[i]  <= res_d[i];
        vout_q[i] <= vout_d[i];
      end
    end
  end

  assign VPU_rdy     = rdy_q;
  assign VPU_data_we = we_q;
  assign V0_out = vout_q[0];
  assign V1_out = vout_q[1];
  assign V2_out = vout_q[2];
  assign V3_out = vout_q[3];
  assign V4_out = vout_q[4];
  assign V5_out = vout_q[5];
  assign V6_out = vout_q[6];
  assign V7_out = vout_q[7];
  assign RO_out = ro_q;

endmodule
`default_nettype wire

// File: tb/tb_vpu_op_responder.sv
`default_nettype none
// Directed bench for vpu_op_responder; expectations follow the VPU_SAT_EN build setting.
module tb_vpu_op_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        VPU_start = 1'b0;
  logic [2:0]  VPU_op = 3'd0;
  logic [15:0] vi [8];
  logic [15:0] RO_in = 16'h0;
  logic        VPU_rdy, VPU_data_we;
  logic [15:0] vo [8];
  logic [15:0] RO_out;

  logic [15:0] exp_v [8];
  logic [15:0] exp_ro;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vpu_op_responder #(.DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .VPU_start(VPU_start), .VPU_op(VPU_op),
    .V0_in(vi[0]), .V1_in(vi[1]), .V2_in(vi[2]), .V3_in(vi[3]),
    .V4_in(vi[4]), .V5_in(vi[5]), .V6_in(vi[6]), .V7_in(vi[7]),
    .RO_in(RO_in), .VPU_rdy(VPU_rdy), .VPU_data_we(VPU_data_we),
    .V0_out(vo[0]), .V1_out(vo[1]), .V2_out(vo[2]), .V3_out(vo[3]),
    .V4_out(vo[4]), .V5_out(vo[5]), .V6_out(vo[6]), .V7_out(vo[7]),
    .RO_out(RO_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string name);
    for (int i = 0; i < 8; i++) check($sformatf("%s V%0d_out", name, i), vo[i], exp_v[i]);
    check({name, " RO_out"}, RO_out, exp_ro);
  endtask

  // Start an op from IDLE and follow it through write-back and return to IDLE.
  task automatic run_op(input logic [2:0] op, input logic [15:0] s, input string name);
    int lat;
    @(negedge clk);
    VPU_op = op; RO_in = s; VPU_start = 1'b1;
    @(negedge clk);
    VPU_start = 1'b0;
    check({name, " rdy low after E0"}, VPU_rdy, 0);
    check({name, " we low after E0"}, VPU_data_we, 0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (VPU_data_we) begin lat = i; break; end
    end
    check({name, " we latency"}, lat, 8);
    check_results(name);
    @(negedge clk);
    check({name, " we low after E9"}, VPU_data_we, 0);
    check({name, " rdy high after E9"}, VPU_rdy, 1);
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < 8; i++) vi[i] = 16'h0;
    repeat (3) @(negedge clk);
    check("reset rdy", VPU_rdy, 1);
    check("reset we", VPU_data_we, 0);
    check("reset V0_out", vo[0], 0);
    check("reset V7_out", vo[7], 0);
    check("reset RO_out", RO_out, 0);
    rst_n = 1'b1;

    // ADD 1..8 + 10
    for (int i = 0; i < 8; i++) begin vi[i] = 16'(i + 1); exp_v[i] = 16'(i + 11); end
    exp_ro = 16'd0;
    run_op(3'b000, 16'd10, "add");

    // SUB with negative overflow on lane 0
    for (int i = 0; i < 8; i++) begin vi[i] = 16'h0; exp_v[i] = 16'hFFFF; end
    vi[0] = 16'h8000;
`ifdef VPU_SAT_EN
    exp_v[0] = 16'h8000;
`else
    exp_v[0] = 16'h7FFF;
`endif
    exp_ro = 16'd1;
    run_op(3'b001, 16'd1, "sub_ovf");

    // ADD with positive overflow on lane 0
    for (int i = 0; i < 8; i++) begin vi[i] = 16'h0; exp_v[i] = 16'h0001; end
    vi[0] = 16'h7FFF;
`ifdef VPU_SAT_EN
    exp_v[0] = 16'h7FFF;
`else
    exp_v[0] = 16'h8000;
`endif
    exp_ro = 16'd1;
    run_op(3'b000, 16'd1, "add_ovf");

    // MUL: every lane 256*256 overflows
    for (int i = 0; i < 8; i++) begin
      vi[i] = 16'h0100;
`ifdef VPU_SAT_EN
      exp_v[i] = 16'h7FFF;
`else
      exp_v[i] = 16'h0000;
`endif
    end
    exp_ro = 16'd8;
    run_op(3'b010, 16'h0100, "mul");

    // SRA by 4
    for (int i = 0; i < 8; i++) begin vi[i] = 16'h0100; exp_v[i] = 16'h0010; end
    vi[0] = 16'hFF00; exp_v[0] = 16'hFFF0;
    exp_ro = 16'd0;
    run_op(3'b100, 16'd4, "sra");

    // SHL uses only S[3:0] (0x13 -> 3)
    for (int i = 0; i < 8; i++) begin vi[i] = 16'(i + 1); exp_v[i] = 16'(8 * (i + 1)); end
    exp_ro = 16'd0;
    run_op(3'b011, 16'h0013, "shl");

    // MAX against 2 with signed lanes
    vi[0] = 16'hFFFF; vi[1] = 16'd5; vi[2] = 16'd2; vi[3] = 16'h8000;
    vi[4] = 16'h7FFF; vi[5] = 16'd3; vi[6] = 16'd0; vi[7] = 16'd1;
    exp_v[0] = 16'd2; exp_v[1] = 16'd5; exp_v[2] = 16'd2; exp_v[3] = 16'd2;
    exp_v[4] = 16'h7FFF; exp_v[5] = 16'd3; exp_v[6] = 16'd2; exp_v[7] = 16'd2;
    exp_ro = 16'd0;
    run_op(3'b110, 16'd2, "max");

    // MIN with the same lanes
    exp_v[0] = 16'hFFFF; exp_v[1] = 16'd2; exp_v[2] = 16'd2; exp_v[3] = 16'h8000;
    exp_v[4] = 16'd2; exp_v[5] = 16'd2; exp_v[6] = 16'd0; exp_v[7] = 16'd1;
    run_op(3'b101, 16'd2, "min");

    // SUM 1..8
    for (int i = 0; i < 8; i++) begin vi[i] = 16'(i + 1); exp_v[i] = 16'(i + 1); end
    exp_ro = 16'h0024;
    run_op(3'b111, 16'd99, "sum");

    // Busy/ignore: start held high through the whole op with different operands
    @(negedge clk);
    for (int i = 0; i < 8; i++) vi[i] = 16'(i + 1);
    VPU_op = 3'b000; RO_in = 16'd10; VPU_start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) vi[i] = 16'h0100;
    VPU_op = 3'b001; RO_in = 16'd1;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (VPU_data_we) pulses++;
      if (k == 8) begin
        check("busy first we", VPU_data_we, 1);
        for (int i = 0; i < 8; i++) exp_v[i] = 16'(i + 11);
        exp_ro = 16'd0;
        check_results("busy first");
      end
      if (k == 9) check("busy rdy after E9", VPU_rdy, 1);
      if (k == 10) begin
        check("busy second accepted", VPU_rdy, 0);
        VPU_start = 1'b0;
      end
      if (k == 18) begin
        check("busy second we", VPU_data_we, 1);
        for (int i = 0; i < 8; i++) exp_v[i] = 16'h00FF;
        check_results("busy second");
      end
    end
    check("busy pulse count", pulses, 2);

    // Reset at E5 of an ADD
    @(negedge clk);
    for (int i = 0; i < 8; i++) vi[i] = 16'(i + 1);
    VPU_op = 3'b000; RO_in = 16'd10; VPU_start = 1'b1;
    @(negedge clk);
    VPU_start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset rdy", VPU_rdy, 1);
    check("midreset we", VPU_data_we, 0);
    check("midreset V0_out", vo[0], 0);
    check("midreset V7_out", vo[7], 0);
    check("midreset RO_out", RO_out, 0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (VPU_data_we) pulses++;
    end
    check("midreset no pulse", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
